// File: rtl/hubris_boot_loader.sv
// -----------------------------------------------------------------------------
// hubris_boot_loader
//
// Start-up sequencer for the Hubris core. While loading, it keeps the core in
// reset and owns memory port A. It receives a framed image from the UART RX
// byte FIFO and writes it word by word into unified memory starting at
// BASE_ADDR. Once the checksum is verified, it returns port A to the core and
// releases core reset.
//
// Frame format (every field is 32-bit little-endian):
//   LEN (N words) | N payload words | CSUM (sum of payload words mod 2^32)
//
// Handshake (valid/ready): a byte is consumed on a rising clk edge where
// in_valid && in_ready. The producer holds in_data stable while in_valid=1 and
// in_ready=0. in_ready never depends on in_valid.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   in_valid/in_data RX byte stream; in_ready accepts a byte
//   mem_sel          1 = loader owns port A, 0 = core owns it
//   mem_en/we/addr/din  port A write interface (active only in WRITE)
//   core_reset       active-high reset to the Hubris core
//   load_done        image loaded and verified (RUN)
//   load_error       sticky failure flag (ERR); error_code gives the cause:
//                    01 = length too large, 10 = checksum, 11 = timeout
//   words_loaded     number of payload words written so far
// -----------------------------------------------------------------------------
module hubris_boot_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 4096,
    parameter int          CNT_W          = 16,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_sel,
    output logic             mem_en,
    output logic [3:0]       mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic             core_reset,
    output logic             load_done,
    output logic             load_error,
    output logic [1:0]       error_code,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam logic [1:0]  ERR_LEN  = 2'b01;
    localparam logic [1:0]  ERR_CSUM = 2'b10;
    localparam logic [1:0]  ERR_TMO  = 2'b11;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);
    // Last count value before expiry; the transition to ERR happens on the
    // edge where the counter would otherwise reach TIMEOUT_CYCLES.
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);

    logic [2:0]       state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [23:0]      asm_q, asm_d;        // lower three bytes of the word being assembled
    logic [31:0]      wr_word_q, wr_word_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [31:0]      csum_q, csum_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             started_q, started_d;
    logic [1:0]       err_q, err_d;

    logic             accepting;
    logic             hs;
    logic             word_done;
    logic [31:0]      full_word;
    logic [CNT_W-1:0] words_inc;
    logic             tmo_run;
    logic             tmo_hit;

    assign accepting = (state_q == ST_LEN) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
    assign hs        = in_valid && accepting;
    assign word_done = hs && (byte_idx_q == 2'd3);
    assign full_word = {in_data, asm_q};
    assign words_inc = words_q + 1'b1;

    // The timer idles until the first byte of a frame. It counts only in the
    // byte-accepting states, and only on cycles without a handshake.
    assign tmo_run = TMO_EN && started_q && accepting && !hs;
    assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wr_word_d  = wr_word_q;
        len_d      = len_q;
        words_d    = words_q;
        csum_d     = csum_q;
        tmo_d      = tmo_q;
        started_d  = started_q;
        err_d      = err_q;

        if (hs) begin
            byte_idx_d = byte_idx_q + 2'd1;
            started_d  = 1'b1;
            tmo_d      = '0;
            case (byte_idx_q)
                2'd0:    asm_d[7:0]   = in_data;
                2'd1:    asm_d[15:8]  = in_data;
                2'd2:    asm_d[23:16] = in_data;
                default: asm_d        = asm_q;
            endcase
        end else if (tmo_run) begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            ST_LEN: begin
                if (word_done) begin
                    len_d = full_word[CNT_W-1:0];
                    if (full_word > MAX_WORDS_W) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                    end else if (full_word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_done) begin
                    wr_word_d = full_word;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                csum_d  = csum_q + wr_word_q;
                words_d = words_inc;
                state_d = (words_inc == len_q) ? ST_CSUM : ST_LOAD;
            end
            ST_CSUM: begin
                if (word_done) begin
                    if (full_word == csum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = state_q;  // RUN and ERR are terminal until reset
            end
        endcase

        // tmo_hit implies no handshake this cycle, so it never competes with
        // a word-completion decision above.
        if (tmo_hit) begin
            state_d = ST_ERR;
            err_d   = ERR_TMO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LEN;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wr_word_q  <= '0;
            len_q      <= '0;
            words_q    <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            started_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wr_word_q  <= wr_word_d;
            len_q      <= len_d;
            words_q    <= words_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            started_q  <= started_d;
            err_q      <= err_d;
        end
    end

    // Port-A drive is gated to WRITE, so address and data stay at zero in
    // every other state, even when BASE_ADDR is non-zero.
    assign in_ready     = accepting;
    assign mem_en       = (state_q == ST_WRITE);
    assign mem_we       = (state_q == ST_WRITE) ? 4'hF : 4'h0;
    assign mem_addr     = (state_q == ST_WRITE) ? (BASE_ADDR + 32'({words_q, 2'b00})) : 32'd0;
    assign mem_din      = (state_q == ST_WRITE) ? wr_word_q : 32'd0;
    assign mem_sel      = (state_q != ST_RUN);
    assign core_reset   = (state_q != ST_RUN);
    assign load_done    = (state_q == ST_RUN);
    assign load_error   = (state_q == ST_ERR);
    assign error_code   = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/hubris_boot_loader.md
Name: hubris_boot_loader

Overview:
- Sequences Hubris start-up. Holds the core in reset and owns memory port A through `mem_sel`.
- Receives a framed program image over a byte stream (the UART RX byte FIFO) and writes it word by word into unified memory starting at `BASE_ADDR`.
- Verifies a checksum, then hands port A back to the core and releases core reset.
- Sits between the SimpleIO-style RX path, the port-A mux and the Hubris reset input.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word; must be 4-byte aligned. Core INST_START_ADDR matches it.
- MAX_WORDS, 4096: largest accepted image length in words.
- CNT_W, 16: width of the word counters and `words_loaded`; 2^CNT_W must exceed MAX_WORDS.
- TIMEOUT_CYCLES, 5_000_000: idle cycles allowed between bytes once a frame has started; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  RX byte available
- in_data  in  8  RX byte
- in_ready  out  1  byte consumed when in_valid && in_ready
- mem_sel  out  1  1 = loader drives port A, 0 = core drives it
- mem_en  out  1  port A enable
- mem_we  out  4  port A byte write enables
- mem_addr  out  32  port A byte address
- mem_din  out  32  port A write data
- core_reset  out  1  reset to Hubris core, active-high
- load_done  out  1  image loaded and verified
- load_error  out  1  load failed (sticky)
- error_code  out  2  01 = length too large, 10 = checksum mismatch, 11 = timeout
- words_loaded  out  CNT_W  words written so far

Behaviour:
- Reset: clk and reset are as stated; reset is synchronous and active-high.
  - State = LEN. in_ready=1, mem_sel=1, core_reset=1, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - load_done=0, load_error=0, error_code=0, words_loaded=0.
  - Byte index, word assembler, checksum and timeout counter are all cleared.
- Frame format, all fields 32-bit little-endian (first byte = bits 7:0): LEN (word count N), then N payload words, then CSUM = sum of payload words mod 2^32.
- Byte assembly: a 2-bit byte index increments per accepted byte. The 4th byte completes a word; the index wraps to 0.
- States:
  - LEN: on word completion, N is latched.
    - N > MAX_WORDS -> ERR, code 01.
    - N == 0 -> CSUM.
    - Otherwise -> LOAD.
  - LOAD: on word completion, go to WRITE for exactly 1 cycle.
  - WRITE: in_ready=0, mem_en=1, mem_we=4'hF, mem_addr=BASE_ADDR + 4*words_loaded, mem_din=word.
    - Checksum += word. words_loaded increments at the end of the cycle.
    - If the incremented count == N -> CSUM, else -> LOAD.
  - CSUM: on word completion, compare with the running sum.
    - Equal -> RUN.
    - Not equal -> ERR, code 10.
  - RUN: mem_sel=0, core_reset=0, load_done=1, in_ready=0. Terminal until reset. Both mem_sel and core_reset drop in the first RUN cycle, so the core's first fetch sees port ownership already returned.
  - ERR: load_error=1, error_code held, in_ready=0, mem_sel=1, core_reset=1. Terminal until reset. Memory already written is left untouched.
- in_ready is 1 in LEN/LOAD/CSUM and 0 in WRITE/RUN/ERR. mem_en=0 and mem_we=0 in every state except WRITE.
- Throughput: at most 1 byte per cycle; 1 bubble cycle per payload word. Write latency is 1 cycle after the 4th byte handshake.
- Timeout:
  - The counter runs only when the frame has started (any byte accepted since reset) and state is LEN/LOAD/CSUM.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERR, code 11.
  - No timeout before the first byte.
- Arithmetic: checksum wraps mod 2^32. mem_addr is computed in 32 bits with no wrap check, because MAX_WORDS bounds it.
- Reset mid-load: returns to LEN immediately. The partial word, count and checksum are discarded; the core is kept in reset. A new frame must start from its LEN field.
- in_valid while in_ready=0: the byte is not consumed; the producer holds it.

Test Plan:
- Load of 2 words:
  - Stimulus: bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | A6 00 10 00.
  - Required: a write of 0x00000013 at 0x0 and of 0x00100093 at 0x4, each with mem_we=F for 1 cycle; in_ready=0 during those cycles.
  - Required end state: RUN with load_done=1, core_reset=0, mem_sel=0, words_loaded=2.
- Empty image: LEN=0 then CSUM=0 -> no memory write; RUN.
- Oversize length: LEN = MAX_WORDS+1 -> ERR, error_code=01, core_reset stays 1, in_ready=0, no writes.
- Bad checksum: the 2-word image with CSUM A7 00 10 00 -> both words written, then ERR, code 10, load_done=0.
- Timeout: set TIMEOUT_CYCLES=100, send 5 bytes then idle -> ERR, code 11, reached exactly 100 cycles after the 5th byte. Idle of 1000 cycles before any byte -> still LEN.
- Reset mid-load: assert reset after the 6th byte, then send the full 2-word frame -> correct RUN with words_loaded=2; the stray bytes produce no effect.
